// File: rtl/priority_queue.sv
//------------------------------------------------------------------------------
// Module   : priority_queue
// Purpose  : Distance table with a continuously registered minimum (value, index).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module priority_queue #(
  parameter int MAX_NODES   = 64,
  parameter int INDEX_WIDTH = 6,
  parameter int VALUE_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   set_en,
  input  logic [INDEX_WIDTH-1:0] index,
  inout  wire  [VALUE_WIDTH-1:0] value,
  output logic [INDEX_WIDTH-1:0] min_index,
  output logic [VALUE_WIDTH-1:0] min_value
);

  localparam int                   LEAVES     = 1 << INDEX_WIDTH;
  localparam logic [VALUE_WIDTH-1:0] INFINITY = {VALUE_WIDTH{1'b1}};
  localparam logic [INDEX_WIDTH:0]   NODE_LIMIT = (INDEX_WIDTH + 1)'(MAX_NODES);

  logic [VALUE_WIDTH-1:0] dist_q [MAX_NODES];
  logic [VALUE_WIDTH-1:0] dist_d [MAX_NODES];
  logic [VALUE_WIDTH-1:0] min_value_q, min_value_d;
  logic [INDEX_WIDTH-1:0] min_index_q, min_index_d;

  logic                   index_valid;
  logic [VALUE_WIDTH-1:0] read_data;

  // Binary heap layout: node n has children 2n and 2n+1, leaves start at LEAVES.
  logic [VALUE_WIDTH-1:0] tree_v [1:2*LEAVES-1];
  logic [INDEX_WIDTH-1:0] tree_i [1:2*LEAVES-1];

  assign index_valid = ({1'b0, index} < NODE_LIMIT);
  assign read_data   = index_valid ? dist_q[index] : INFINITY;
  assign value       = set_en ? {VALUE_WIDTH{1'bz}} : read_data;

  always_comb begin
    dist_d = dist_q;
    if (reset) begin
      for (int k = 0; k < MAX_NODES; k++) begin
        dist_d[k] = INFINITY;
      end
      dist_d[0] = '0;
    end else if (set_en && index_valid) begin
      dist_d[index] = value;
    end
  end

  // Strict less-than on the right child keeps the lower index on ties;
  // padding leaves hold INFINITY so they never beat a real entry.
  always_comb begin
    for (int k = 0; k < MAX_NODES; k++) begin
      tree_v[LEAVES + k] = dist_q[k];
      tree_i[LEAVES + k] = INDEX_WIDTH'(k);
    end
    for (int k = MAX_NODES; k < LEAVES; k++) begin
      tree_v[LEAVES + k] = INFINITY;
      tree_i[LEAVES + k] = INDEX_WIDTH'(k);
    end
    for (int n = LEAVES - 1; n >= 1; n--) begin
      if (tree_v[2*n + 1] < tree_v[2*n]) begin
        tree_v[n] = tree_v[2*n + 1];
        tree_i[n] = tree_i[2*n + 1];
      end else begin
        tree_v[n] = tree_v[2*n];
        tree_i[n] = tree_i[2*n];
      end
    end
  end

  always_comb begin
    min_value_d = tree_v[1];
    min_index_d = tree_i[1];
    if (reset) begin
      min_value_d = '0;
      min_index_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    dist_q      <= dist_d;
    min_value_q <= min_value_d;
    min_index_q <= min_index_d;
  end

  assign min_value = min_value_q;
  assign min_index = min_index_q;

endmodule

`default_nettype wire

// File: tb/tb_priority_queue.sv
//------------------------------------------------------------------------------
// Module   : tb_priority_queue
// Purpose  : Randomized self-checking bench for priority_queue against a table model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_priority_queue;

  localparam int MAX_NODES   = 64;
  localparam int INDEX_WIDTH = 6;
  localparam int VALUE_WIDTH = 16;
  localparam int INF         = 65535;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   set_en;
  logic [INDEX_WIDTH-1:0] index;
  logic [VALUE_WIDTH-1:0] tb_data;
  wire  [VALUE_WIDTH-1:0] value;
  logic [INDEX_WIDTH-1:0] min_index;
  logic [VALUE_WIDTH-1:0] min_value;

  int checks   = 0;
  int failures = 0;
  int model [MAX_NODES];

  assign value = set_en ? tb_data : {VALUE_WIDTH{1'bz}};

  always #5 clock = ~clock;

  priority_queue #(
    .MAX_NODES  (MAX_NODES),
    .INDEX_WIDTH(INDEX_WIDTH),
    .VALUE_WIDTH(VALUE_WIDTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .set_en   (set_en),
    .index    (index),
    .value    (value),
    .min_index(min_index),
    .min_value(min_value)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < MAX_NODES; k++) model[k] = INF;
    model[0] = 0;
  endtask

  task automatic model_min(output int mv, output int mi);
    mv = model[0];
    mi = 0;
    for (int k = 1; k < MAX_NODES; k++) begin
      if (model[k] < mv) begin
        mv = model[k];
        mi = k;
      end
    end
  endtask

  task automatic write_entry(input int idx, input int val);
    set_en  = 1'b1;
    index   = INDEX_WIDTH'(idx);
    tb_data = VALUE_WIDTH'(val);
    tick();
    set_en  = 1'b0;
    model[idx] = val;
  endtask

  task automatic read_check(input string tag, input int idx);
    set_en = 1'b0;
    index  = INDEX_WIDTH'(idx);
    #1;
    check_eq(tag, int'(value), model[idx]);
  endtask

  task automatic min_check(input string tag);
    int mv, mi;
    model_min(mv, mi);
    check_eq({tag, "_value"}, int'(min_value), mv);
    check_eq({tag, "_index"}, int'(min_index), mi);
  endtask

  initial begin
    int old_v, old_i, idx, val;

    reset   = 1'b1;
    set_en  = 1'b0;
    index   = '0;
    tb_data = '0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;

    min_check("reset_min");
    for (int k = 0; k < MAX_NODES; k++) read_check("reset_read", k);

    // Removing the source leaves every entry at INFINITY.
    write_entry(0, INF);
    tick();
    check_eq("all_inf_value", int'(min_value), INF);
    check_eq("all_inf_index", int'(min_index), 0);

    write_entry(17, 42);
    write_entry(30, 7);
    write_entry(5, 7);
    read_check("raw_17", 17);
    read_check("raw_30", 30);
    read_check("raw_5", 5);
    tick();
    check_eq("tie_value", int'(min_value), 7);
    check_eq("tie_index", int'(min_index), 5);

    for (int n = 0; n < 10; n++) begin
      idx = int'($urandom_range(49, 0));
      val = int'($urandom_range(49, 0));
      write_entry(idx, val);
      tick();
      read_check("rand_read", idx);
      min_check("rand_min");
    end

    // Minimum latency and bus ownership during a write.
    model_min(old_v, old_i);
    set_en  = 1'b1;
    index   = 6'd3;
    tb_data = 16'd1;
    #1;
    check_eq("bus_no_drive", int'(value), 1);
    tick();
    set_en   = 1'b0;
    model[3] = 1;
    check_eq("lat_edge_value", int'(min_value), old_v);
    check_eq("lat_edge_index", int'(min_index), old_i);
    tick();
    min_check("lat_next");
    read_check("lat_read", 3);

    // Reset asserted on the same edge as a write.
    set_en  = 1'b1;
    index   = 6'd9;
    tb_data = 16'd2;
    reset   = 1'b1;
    tick();
    reset  = 1'b0;
    set_en = 1'b0;
    model_reset();
    read_check("mid_rst_9", 9);
    read_check("mid_rst_0", 0);
    check_eq("mid_rst_min_value", int'(min_value), 0);
    check_eq("mid_rst_min_index", int'(min_index), 0);

    // Wider random traffic, including large values and consecutive writes.
    for (int n = 0; n < 20; n++) begin
      idx = int'($urandom_range(MAX_NODES - 1, 0));
      val = ($urandom_range(3, 0) == 0) ? INF : int'($urandom_range(INF - 1, 0));
      write_entry(idx, val);
      if (n % 4 == 3) begin
        tick();
        min_check("burst_min");
        read_check("burst_read", int'($urandom_range(MAX_NODES - 1, 0)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/priority_queue.md
Name: priority_queue

Overview:
- Distance table and minimum finder for a Dijkstra shortest-path engine.
- Holds MAX_NODES distance entries, each readable and writable through one shared bidirectional value bus.
- Continuously reports the smallest stored distance and the node index that holds it.
- The path-search controller uses it to pick the next node to visit.

Parameters:
- MAX_NODES, 64: number of node entries; must be at most 2^INDEX_WIDTH.
- INDEX_WIDTH, 6: width of node index buses.
- VALUE_WIDTH, 16: width of a distance value. INFINITY is all-ones ({VALUE_WIDTH{1'b1}}).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- set_en  in  1  1 = write cycle, with the bus driven externally; 0 = read cycle, with the bus driven by the block.
- index  in  INDEX_WIDTH  entry selected for read or write.
- value  inout  VALUE_WIDTH  shared data bus.
- min_index  out  INDEX_WIDTH  index of the minimum entry.
- min_value  out  VALUE_WIDTH  value of the minimum entry.

Behaviour:
- Interface: one clock domain; clock and reset as named above. Reset is synchronous and active-high.
- Storage: dist[0..MAX_NODES-1], VALUE_WIDTH bits each, held in registers.
- Reset, sampled at a rising edge while reset=1:
  - dist[0] = 0; dist[1..MAX_NODES-1] = INFINITY.
  - min_index = 0; min_value = 0.
  - Reset has priority over set_en; writes are ignored while reset=1.
- Bus drive:
  - set_en=0: the block drives value = dist[index] combinationally. Read data follows index changes with zero clock latency.
  - set_en=1: the block tristates value (all z).
  - Out-of-range index (>= MAX_NODES) reads as INFINITY.
- Write:
  - At a rising edge with reset=0 and set_en=1, dist[index] <= value.
  - Writes to out-of-range indices are ignored.
  - Writing INFINITY is legal and marks the node as removed or unreached.
  - Consecutive write cycles each commit one entry.
- Minimum:
  - A combinational min-reduction over all entries selects the smallest value. Ties resolve to the lowest index.
  - The selected value and its index are registered into min_value and min_index at every rising edge where reset=0.
  - Latency: the outputs reflect the table contents as they stood before that edge. After a write at edge N, the minimum outputs show the new minimum after edge N+1.
  - If all entries are INFINITY, min_value = INFINITY and min_index = 0.
- No other state; no handshake beyond set_en.
- Reset mid-operation discards all contents and returns to the reset state at that edge.

Test Plan:
- Reset: hold reset=1 for two edges, then release. Sweep index 0..MAX_NODES-1 with set_en=0.
  - Required: value = 0 at index 0 and 65535 at every other index.
  - Required: min_value = 0 and min_index = 0.
- Source removal: after reset, write index 0 = 65535 with set_en=1, then wait two edges.
  - Required: min_value = 65535 and min_index = 0 (all-INFINITY tie).
- Read-after-write: write index 17 = 42, then index 30 = 7, then index 5 = 7, and read back each entry with set_en=0.
  - Required: read-back values are 42, 7 and 7.
  - Required: min_value = 7 and min_index = 5 (lowest-index tie).
- Minimum tracking: perform 10 random writes (index < 50, value < 50) and compare against a reference model after two edges each.
  - Required: value read-back equals the written data.
  - Required: min_value and min_index equal the model's minimum (lowest index on ties).
- Latency and bus: write index 3 = 1.
  - Required: the minimum outputs are unchanged at the edge of the write and show 1/3 one edge later.
  - Required: while set_en=1, the block does not drive value (no contention).
- Reset mid-stream: assert reset during a write of index 9 = 2.
  - Required: dist[9] = 65535, dist[0] = 0, and min_value = 0 after the reset edge.
